// File: rtl/bp_update_arbiter_if.sv
// bp_update_arbiter_if: pipeline/trace update requests in, predictor write port, drain control and statistics out
interface bp_update_arbiter_if #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                       pipe_upd_valid;
  logic [PC_W-1:0]            pipe_upd_pc;
  logic                       pipe_upd_taken;
  logic                       pipe_upd_pred;
  logic                       trace_upd_valid;
  logic                       trace_upd_ready;
  logic [PC_W-1:0]            trace_upd_pc;
  logic                       trace_upd_taken;
  logic                       trace_upd_pred;
  logic                       drain_req;
  logic                       drain_done;
  logic                       stat_clr;
  logic                       bp_update;
  logic [PC_W-1:0]            bp_update_pc;
  logic                       bp_actual_taken;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic [CNT_W-1:0]           stat_updates;
  logic [CNT_W-1:0]           stat_mispredicts;
  modport master (
    output pipe_upd_valid, pipe_upd_pc, pipe_upd_taken, pipe_upd_pred,
    output trace_upd_valid, trace_upd_pc, trace_upd_taken, trace_upd_pred,
    output drain_req, stat_clr,
    input  trace_upd_ready, drain_done, bp_update, bp_update_pc, bp_actual_taken,
    input  fifo_count, stat_updates, stat_mispredicts
  );
  modport slave (
    input  pipe_upd_valid, pipe_upd_pc, pipe_upd_taken, pipe_upd_pred,
    input  trace_upd_valid, trace_upd_pc, trace_upd_taken, trace_upd_pred,
    input  drain_req, stat_clr,
    output trace_upd_ready, drain_done, bp_update, bp_update_pc, bp_actual_taken,
    output fifo_count, stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/bp_update_arbiter.sv
// bp_update_arbiter: muxes pipeline (priority) and FIFO-buffered trace updates onto the predictor update port; clk, rst (async high), bus (slave) carries requests, drain, stats
module bp_update_arbiter #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  bp_update_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [PC_W+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, issue, iss_taken, iss_pred;
  logic [PC_W-1:0] iss_pc;
  assign bus.trace_upd_ready = !rst && state == RUN && count < FULL;
  assign bus.drain_done = state == DONE;
  assign bus.fifo_count = count;
  assign push = bus.trace_upd_valid && bus.trace_upd_ready;
  assign pop = !bus.pipe_upd_valid && count != '0;
  assign issue = bus.pipe_upd_valid || pop;
  assign {iss_pc, iss_taken, iss_pred} = bus.pipe_upd_valid ?
    {bus.pipe_upd_pc, bus.pipe_upd_taken, bus.pipe_upd_pred} : mem[rd_ptr];
  always_comb begin
    state_nx = state;
    state_nx = state == RUN   ? (bus.drain_req ? DRAIN : RUN) :
               state == DRAIN ? (count == '0 ? DONE : DRAIN) : RUN;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.trace_upd_pc, bus.trace_upd_taken, bus.trace_upd_pred};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.bp_update <= 1'b0;
      bus.bp_update_pc <= '0;
      bus.bp_actual_taken <= 1'b0;
      bus.stat_updates <= '0;
      bus.stat_mispredicts <= '0;
    end else begin
      state <= state_nx;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      bus.bp_update <= issue;
      bus.bp_update_pc <= issue ? iss_pc : bus.bp_update_pc;
      bus.bp_actual_taken <= issue ? iss_taken : bus.bp_actual_taken;
      bus.stat_updates <= bus.stat_clr ? '0 :
        (issue && bus.stat_updates != CNT_MAX) ? bus.stat_updates + CNT_W'(1) : bus.stat_updates;
      bus.stat_mispredicts <= bus.stat_clr ? '0 :
        (issue && iss_pred != iss_taken && bus.stat_mispredicts != CNT_MAX) ?
        bus.stat_mispredicts + CNT_W'(1) : bus.stat_mispredicts;
    end
  end
endmodule

// File: tb/tb_bp_update_arbiter.sv
// tb_bp_update_arbiter: directed stimulus with an expected-issue queue checked by a separate monitor
module tb_bp_update_arbiter;
  localparam int PC_W = 10;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [PC_W:0] exp_q[$];
  logic [PC_W:0] e;
  always #5 clk = ~clk;
  bp_update_arbiter_if #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  bp_update_arbiter #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.bp_update) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_issue: got pc 0x%0h taken %0b expected no issue", bus.bp_update_pc, bus.bp_actual_taken);
      end else begin
        e = exp_q.pop_front();
        chk("issue_pc", 32'(bus.bp_update_pc), 32'(e[PC_W:1]));
        chk("issue_taken", 32'(bus.bp_actual_taken), 32'(e[0]));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pipe(input logic v, input logic [PC_W-1:0] pc, input logic t, input logic p);
    bus.pipe_upd_valid = v;
    bus.pipe_upd_pc = pc;
    bus.pipe_upd_taken = t;
    bus.pipe_upd_pred = p;
  endtask
  task automatic trace(input logic v, input logic [PC_W-1:0] pc, input logic t, input logic p);
    bus.trace_upd_valid = v;
    bus.trace_upd_pc = pc;
    bus.trace_upd_taken = t;
    bus.trace_upd_pred = p;
  endtask
  task automatic idle();
    pipe(1'b0, '0, 1'b0, 1'b0);
    trace(1'b0, '0, 1'b0, 1'b0);
    bus.drain_req = 1'b0;
    bus.stat_clr = 1'b0;
  endtask
  task automatic wait_q(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic clear_stats();
    bus.stat_clr = 1'b1;
    tick();
    bus.stat_clr = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    #12;
    chk("rst_bp_update", 32'(bus.bp_update), 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ready", 32'(bus.trace_upd_ready), 32'd0);
    chk("rst_drain_done", 32'(bus.drain_done), 32'd0);
    chk("rst_stat_updates", 32'(bus.stat_updates), 32'd0);
    chk("rst_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.trace_upd_ready), 32'd1);
    exp_q.push_back({10'h012, 1'b1});
    trace(1'b1, 10'h012, 1'b1, 1'b0);
    tick();
    trace(1'b0, '0, 1'b0, 1'b0);
    chk("t1_count_after_push", 32'(bus.fifo_count), 32'd1);
    chk("t1_no_fallthrough", 32'(bus.bp_update), 32'd0);
    tick();
    chk("t1_issue_cycle3", 32'(bus.bp_update), 32'd1);
    chk("t1_count_after_pop", 32'(bus.fifo_count), 32'd0);
    chk("t1_stat_updates", 32'(bus.stat_updates), 32'd1);
    chk("t1_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd1);
    tick();
    chk("t1_idle_update", 32'(bus.bp_update), 32'd0);
    chk("t1_hold_pc", 32'(bus.bp_update_pc), 32'h012);
    clear_stats();
    chk("clr_stat_updates", 32'(bus.stat_updates), 32'd0);
    for (int k = 0; k < 6; k++) exp_q.push_back({10'(32'h100 + k), 1'(k)});
    for (int k = 0; k < 4; k++) exp_q.push_back({10'(32'h020 + k), 1'b1});
    for (int k = 0; k < 6; k++) begin
      pipe(1'b1, 10'(32'h100 + k), 1'(k), 1'b0);
      if (k < 4) trace(1'b1, 10'(32'h020 + k), 1'b1, 1'b1);
      else trace(1'b0, '0, 1'b0, 1'b0);
      tick();
      if (k == 3) begin
        chk("t2_count_full", 32'(bus.fifo_count), 32'd4);
        chk("t2_ready_full", 32'(bus.trace_upd_ready), 32'd0);
      end
    end
    idle();
    wait_q(20);
    chk("t2_stat_updates", 32'(bus.stat_updates), 32'd10);
    chk("t2_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd3);
    chk("t2_count_empty", 32'(bus.fifo_count), 32'd0);
    chk("t2_ready_back", 32'(bus.trace_upd_ready), 32'd1);
    clear_stats();
    exp_q.push_back({10'h03A, 1'b1});
    exp_q.push_back({10'h005, 1'b0});
    trace(1'b1, 10'h005, 1'b0, 1'b1);
    tick();
    trace(1'b0, '0, 1'b0, 1'b0);
    pipe(1'b1, 10'h03A, 1'b1, 1'b1);
    tick();
    pipe(1'b0, '0, 1'b0, 1'b0);
    chk("t3_pipe_first", 32'(bus.bp_update_pc), 32'h03A);
    chk("t3_count_held", 32'(bus.fifo_count), 32'd1);
    tick();
    chk("t3_fifo_next", 32'(bus.bp_update_pc), 32'h005);
    chk("t3_count_dec", 32'(bus.fifo_count), 32'd0);
    wait_q(5);
    chk("t3_stat_updates", 32'(bus.stat_updates), 32'd2);
    chk("t3_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd1);
    for (int k = 0; k < 3; k++) exp_q.push_back({10'(32'h200 + k), 1'b0});
    for (int k = 0; k < 3; k++) exp_q.push_back({10'(32'h031 + k), 1'b1});
    for (int k = 0; k < 3; k++) begin
      pipe(1'b1, 10'(32'h200 + k), 1'b0, 1'b0);
      trace(1'b1, 10'(32'h031 + k), 1'b1, 1'b1);
      tick();
    end
    chk("t4_count_filled", 32'(bus.fifo_count), 32'd3);
    idle();
    bus.drain_req = 1'b1;
    tick();
    chk("t4_ready_drain", 32'(bus.trace_upd_ready), 32'd0);
    chk("t4_count_2", 32'(bus.fifo_count), 32'd2);
    chk("t4_no_done_early", 32'(bus.drain_done), 32'd0);
    trace(1'b1, 10'h3FF, 1'b1, 1'b1);
    tick();
    trace(1'b0, '0, 1'b0, 1'b0);
    bus.drain_req = 1'b0;
    chk("t4_no_push_in_drain", 32'(bus.fifo_count), 32'd1);
    tick();
    chk("t4_count_0", 32'(bus.fifo_count), 32'd0);
    chk("t4_done_not_yet", 32'(bus.drain_done), 32'd0);
    tick();
    chk("t4_drain_done", 32'(bus.drain_done), 32'd1);
    chk("t4_ready_in_done", 32'(bus.trace_upd_ready), 32'd0);
    tick();
    chk("t4_done_one_cycle", 32'(bus.drain_done), 32'd0);
    chk("t4_ready_restored", 32'(bus.trace_upd_ready), 32'd1);
    wait_q(5);
    clear_stats();
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back({10'(32'h300 + i), 1'b1});
      pipe(1'b1, 10'(32'h300 + i), 1'b1, 1'b0);
      tick();
    end
    chk("t5_mispredicts_sat", 32'(bus.stat_mispredicts), 32'd15);
    chk("t5_updates_sat", 32'(bus.stat_updates), 32'd15);
    exp_q.push_back({10'h320, 1'b0});
    pipe(1'b1, 10'h320, 1'b0, 1'b0);
    bus.stat_clr = 1'b1;
    tick();
    idle();
    chk("t5_clr_wins_updates", 32'(bus.stat_updates), 32'd0);
    chk("t5_clr_wins_mispredicts", 32'(bus.stat_mispredicts), 32'd0);
    wait_q(5);
    exp_q.push_back({10'h210, 1'b1});
    for (int k = 0; k < 2; k++) begin
      pipe(1'b1, 10'(32'h210 + k), 1'b1, 1'b1);
      trace(1'b1, 10'(32'h041 + k), 1'b0, 1'b0);
      tick();
    end
    chk("t6_count_queued", 32'(bus.fifo_count), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    idle();
    chk("t6_rst_bp_update", 32'(bus.bp_update), 32'd0);
    chk("t6_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("t6_rst_ready", 32'(bus.trace_upd_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("t6_count_after", 32'(bus.fifo_count), 32'd0);
    chk("t6_ready_after", 32'(bus.trace_upd_ready), 32'd1);
    chk("t6_no_stale_issue", 32'(bus.bp_update), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
